keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles per scan tick (≥2).
REQ-002 Parameter DEBOUNCE_TICKS, default 20, consecutive stable ticks to accept a press or release (≥1).
REQ-003 clk  input  1  system clock; all state on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 col  input  4  keypad column lines, active-low, asynchronous to clk.
REQ-006 clr  input  1  synchronous clear of number, active-high.
REQ-007 row  output  4  keypad row drive, active-low, exactly one row low at any time.
REQ-008 key_valid  output  1  one-cycle pulse per accepted key press.
REQ-009 key_code  output  4  code of last accepted key, {row_idx[1:0], col_idx[1:0]}.
REQ-010 number  output  32  hex entry register, suitable for the 32-bit display input.

Function
REQ-011 col SHALL pass through a 2-flop synchronizer (reset 4'hF); only the synchronized value is used.
REQ-012 Prescaler SHALL count 0..SCAN_DIV-1, wrap to 0, and assert internal tick for the one cycle where count == SCAN_DIV-1.
REQ-013 row_idx (2 bits) SHALL select row: row = ~(4'b0001 << row_idx).
REQ-014 A sample is "single-key" when exactly one bit of synchronized col is 0; col_idx = index of that bit; zero or multiple low bits = "no key".
REQ-015 FSM states: SCAN, DEBOUNCE, HELD, RELEASE; all transitions occur only on tick cycles.
REQ-016 SCAN: on tick with single-key -> DEBOUNCE, latch col_idx, stable count = 1, row_idx held; otherwise row_idx increments mod 4 (3 -> 0).
REQ-017 DEBOUNCE: on tick, same single-key col_idx -> count+1; differing or no key -> SCAN (row_idx unchanged, no output).
REQ-018 DEBOUNCE: when count reaches DEBOUNCE_TICKS -> HELD; key_valid = 1 on the following clk cycle only; key_code updated in that same cycle.
REQ-019 HELD: row_idx held; on tick with no key -> RELEASE with count = 1; any key pattern stays HELD; held key never repeats key_valid.
REQ-020 RELEASE: on tick, no key -> count+1, reaching DEBOUNCE_TICKS -> SCAN with row_idx+1; any key -> HELD.
REQ-021 In the key_valid cycle, number <= {number[27:0], key_code}; oldest nibble discarded (wrap-around by shifting).
REQ-022 clr = 1 sets number to 32'h0 on the next edge; clr and key_valid in the same cycle -> number = 0 (clr wins), key_code still updated.
REQ-023 clr SHALL NOT affect FSM, row, key_code or key_valid.
REQ-024 Latency press-stable to key_valid: ≤ (DEBOUNCE_TICKS+1)·SCAN_DIV + 3 clk cycles from row reaching the key.

Reset
REQ-025 rst_n low SHALL asynchronously force: state SCAN, prescaler 0, row_idx 0 (row = 4'b1110), key_valid 0, key_code 0, number 0, debounce count 0, synchronizer 4'hF.
REQ-026 Reset asserted mid-DEBOUNCE or HELD SHALL abandon the key with no key_valid; after release, scanning restarts at row 0 with no spurious press from stale state.

Verification (SCAN_DIV=4, DEBOUNCE_TICKS=3)
REQ-027 Idle, col = 4'hF -> row cycles 1110,1101,1011,0111,1110 changing every 4 clk; key_valid never 1.
REQ-028 Key row 2/col 1 held (col = 4'b1101 while row = 4'b1011) -> exactly one key_valid, key_code = 4'h9, number = 32'h0000_0009; row stays 4'b1011 until release debounced.
REQ-029 Press sequence 1,2,...,8 then key 0xA -> number = 32'h2345_678A after last pulse (nibble 1 shifted out).
REQ-030 Bounce: col toggles single-key/no-key every tick for 10 ticks then stays 4'hF -> no key_valid, FSM returns to SCAN.
REQ-031 Two columns low (col = 4'b1100) for 20 ticks -> no key_valid; clr pulse coincident with a key_valid -> number = 0, key_code = new key.
REQ-032 rst_n low during HELD -> row = 4'b1110, number = 0, key_valid = 0 immediately; no pulse after release.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix keypad scanner with debounce and a hex entry shift register
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  col,
    input  logic        clr,
    output logic [3:0]  row,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [31:0] number
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_MAX  = CW'(DEBOUNCE_TICKS);
    localparam logic [CW-1:0] DB_ONE  = CW'(1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_e;

    state_e        state_q, state_d;
    logic [3:0]    col_meta_q, col_sync_q;
    logic [PW-1:0] pre_q;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [1:0]    cidx_q, cidx_d;
    logic [CW-1:0] dcnt_q, dcnt_d;
    logic          valid_q, fire;
    logic [3:0]    code_q;
    logic [31:0]   number_q;
    logic          tick, single;
    logic [1:0]    cidx;
    logic [CW-1:0] dcnt_inc;

    assign tick     = pre_q == PRE_MAX;
    assign single   = (col_sync_q == 4'b1110) | (col_sync_q == 4'b1101) |
                      (col_sync_q == 4'b1011) | (col_sync_q == 4'b0111);
    assign cidx     = {~col_sync_q[3] | ~col_sync_q[2], ~col_sync_q[3] | ~col_sync_q[1]};
    assign dcnt_inc = dcnt_q + 1'b1;

    assign row       = ~(4'b0001 << row_idx_q);
    assign key_valid = valid_q;
    assign key_code  = code_q;
    assign number    = number_q;

    // two-flop synchronizer for the asynchronous column lines (idle high)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_q <= 4'hF;
            col_sync_q <= 4'hF;
        end else begin
            col_meta_q <= col;
            col_sync_q <= col_meta_q;
        end
    end

    // scan prescaler; tick marks the last count before wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_q <= '0;
        else        pre_q <= tick ? '0 : pre_q + 1'b1;
    end

    // FSM state, scanned row, latched column and debounce counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SCAN;
            row_idx_q <= 2'd0;
            cidx_q    <= 2'd0;
            dcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            row_idx_q <= row_idx_d;
            cidx_q    <= cidx_d;
            dcnt_q    <= dcnt_d;
        end
    end

    // next-state logic; every transition waits for a scan tick
    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        cidx_d    = cidx_q;
        dcnt_d    = dcnt_q;
        fire      = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (single) begin
                        cidx_d  = cidx;
                        dcnt_d  = DB_ONE;
                        fire    = DB_ONE == DB_MAX;
                        state_d = fire ? HELD : DEBOUNCE;
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (single && cidx == cidx_q) begin
                        dcnt_d  = dcnt_inc;
                        fire    = dcnt_inc == DB_MAX;
                        state_d = fire ? HELD : DEBOUNCE;
                    end else begin
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    if (!single) begin
                        dcnt_d    = DB_ONE;
                        state_d   = (DB_ONE == DB_MAX) ? SCAN : RELEASE;
                        row_idx_d = (DB_ONE == DB_MAX) ? row_idx_q + 2'd1 : row_idx_q;
                    end
                end
                RELEASE: begin
                    if (!single) begin
                        dcnt_d    = dcnt_inc;
                        state_d   = (dcnt_inc == DB_MAX) ? SCAN : RELEASE;
                        row_idx_d = (dcnt_inc == DB_MAX) ? row_idx_q + 2'd1 : row_idx_q;
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    // key pulse, key code capture and hex entry shift; clear only touches the entry register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            code_q   <= 4'h0;
            number_q <= 32'h0;
        end else begin
            valid_q <= fire;
            if (fire) code_q <= {row_idx_q, cidx_d};
            if (clr)          number_q <= 32'h0;
            else if (valid_q) number_q <= {number_q[27:0], code_q};
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed self-checking bench for keypad_scanner with a modelled keypad matrix
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DT = 3;

    typedef struct {
        logic [3:0]  key;
        logic [31:0] num;
    } press_t;

    typedef struct {
        int         cyc;
        logic [3:0] row;
    } idle_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [3:0]  col, row, key_code;
    logic        key_valid;
    logic [31:0] number;
    logic        key_on = 1'b0;
    logic        force_en = 1'b0;
    logic [3:0]  key = 4'h0;
    logic [3:0]  force_col = 4'hF;
    logic        kv_prev = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          pulses = 0;
    int          doubles = 0;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(DT)) dut (
        .clk(clk), .rst_n(rst_n), .col(col), .clr(clr),
        .row(row), .key_valid(key_valid), .key_code(key_code), .number(number)
    );

    always #5 clk = ~clk;

    assign col = force_en ? force_col :
                 (key_on && row == ~(4'b0001 << key[3:2])) ? ~(4'b0001 << key[1:0]) : 4'hF;

    always @(posedge clk) begin
        if (key_valid) pulses++;
        if (key_valid && kv_prev) doubles++;
        kv_prev = key_valid;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_press(input logic [3:0] k, input logic [31:0] exp_num);
        logic [3:0] krow, prow;
        int c0, lat, i;
        krow = ~(4'b0001 << k[3:2]);
        prow = {krow[0], krow[3:1]};
        key = k;
        for (i = 0; i < 64 && row !== prow; i++) @(negedge clk);
        check($sformatf("pre_row_%0h", k), row, prow);
        key_on = 1'b1;
        for (i = 0; i < 64 && row !== krow; i++) @(negedge clk);
        c0 = pulses;
        for (lat = 0; lat < 64 && pulses == c0; lat++) @(negedge clk);
        check($sformatf("latency_%0h", k), lat, DT * SD + 1);
        check($sformatf("key_code_%0h", k), key_code, k);
        check($sformatf("number_%0h", k), number, exp_num);
        repeat (20) @(negedge clk);
        check($sformatf("held_row_%0h", k), row, krow);
        key_on = 1'b0;
        repeat (6) @(negedge clk);
        check($sformatf("release_row_%0h", k), row, krow);
        repeat (30) @(negedge clk);
        check($sformatf("pulse_count_%0h", k), pulses - c0, 1);
    endtask

    initial begin
        press_t     tab[9];
        idle_t      idle_tab[6];
        int         cyc, c0, i;
        logic [3:0] r0;
        tab[0] = '{4'h1, 32'h0000_0001};
        tab[1] = '{4'h2, 32'h0000_0012};
        tab[2] = '{4'h3, 32'h0000_0123};
        tab[3] = '{4'h4, 32'h0000_1234};
        tab[4] = '{4'h5, 32'h0001_2345};
        tab[5] = '{4'h6, 32'h0012_3456};
        tab[6] = '{4'h7, 32'h0123_4567};
        tab[7] = '{4'h8, 32'h1234_5678};
        tab[8] = '{4'hA, 32'h2345_678A};
        idle_tab[0] = '{3,  4'b1110};
        idle_tab[1] = '{4,  4'b1101};
        idle_tab[2] = '{7,  4'b1101};
        idle_tab[3] = '{8,  4'b1011};
        idle_tab[4] = '{12, 4'b0111};
        idle_tab[5] = '{16, 4'b1110};

        repeat (2) @(negedge clk);
        check("rst_row", row, 4'b1110);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_key_code", key_code, 4'h0);
        check("rst_number", number, 32'h0);

        rst_n = 1'b1;
        cyc = 0;
        for (int j = 0; j < 6; j++) begin
            while (cyc < idle_tab[j].cyc) begin
                @(negedge clk);
                cyc++;
            end
            check($sformatf("idle_row_c%0d", idle_tab[j].cyc), row, idle_tab[j].row);
        end
        check("idle_no_pulse", pulses, 0);

        do_press(4'h9, 32'h0000_0009);

        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_number", number, 32'h0);

        for (int j = 0; j < 9; j++) do_press(tab[j].key, tab[j].num);

        force_en = 1'b1;
        c0 = pulses;
        for (int j = 0; j < 10; j++) begin
            force_col = (j % 2 == 0) ? 4'b1110 : 4'hF;
            repeat (SD) @(negedge clk);
        end
        force_col = 4'hF;
        repeat (20) @(negedge clk);
        check("bounce_no_pulse", pulses - c0, 0);
        r0 = row;
        repeat (SD) @(negedge clk);
        check("bounce_scan_resumes", row, {r0[2:0], r0[3]});

        force_col = 4'b1100;
        repeat (20 * SD) @(negedge clk);
        force_col = 4'hF;
        repeat (4) @(negedge clk);
        check("two_col_no_pulse", pulses - c0, 0);
        r0 = row;
        repeat (SD) @(negedge clk);
        check("two_col_scan_resumes", row, {r0[2:0], r0[3]});
        force_en = 1'b0;

        key = 4'h5;
        key_on = 1'b1;
        for (i = 0; i < 200 && key_valid !== 1'b1; i++) @(negedge clk);
        check("clr_pulse_seen", key_valid, 1'b1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_wins_number", number, 32'h0);
        check("clr_key_code", key_code, 4'h5);
        check("clr_pulse_one_cycle", key_valid, 1'b0);
        key_on = 1'b0;
        repeat (40) @(negedge clk);

        key = 4'h6;
        key_on = 1'b1;
        c0 = pulses;
        for (i = 0; i < 200 && pulses == c0; i++) @(negedge clk);
        check("pre_reset_number", number, 32'h0000_0006);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("held_rst_row", row, 4'b1110);
        check("held_rst_number", number, 32'h0);
        check("held_rst_key_valid", key_valid, 1'b0);
        check("held_rst_key_code", key_code, 4'h0);
        key_on = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        c0 = pulses;
        repeat (60) @(negedge clk);
        check("post_reset_no_pulse", pulses - c0, 0);
        check("single_cycle_pulses", doubles, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
